// File: rtl/reg_cmd_ctrl.sv
// rtl/reg_cmd_ctrl.sv - byte-stream command decoder driving a register file
//
// Purpose: decodes a serial command stream into register accesses.
//   0xAA <addr> <data> : write <data> to <addr>
//   0xBB <addr>        : read <addr>, return the read byte on the TX side
// Any other opcode, or a byte arriving while a read is outstanding, pulses ERR.
//
// Ports:
//   CLK, RST                : clock, asynchronous active-low reset
//   RX_P_DATA / RX_D_VLD    : incoming command bytes (one-cycle valid pulses)
//   RdData / RdData_VLD     : read data returned by the register file
//   TX_BUSY                 : transmitter busy, holds off TX_D_VLD
//   WrEn / RdEn             : one-cycle register access requests
//   Address / WrData        : register address and write data (held)
//   TX_P_DATA / TX_D_VLD    : response byte and its one-cycle strobe
//   ERR                     : one-cycle error pulse
module reg_cmd_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ADDR    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_VLD,
    input  logic             TX_BUSY,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_vld_q, tx_vld_d;
    logic             err_q, err_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR)      state_d = WR_ADDR;
                    else if (RX_P_DATA == CMD_RD) state_d = RD_ADDR;
                    else                          err_d   = 1'b1;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = RX_P_DATA;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR-1:0];
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // A stray byte is dropped but flagged; the read keeps waiting.
                if (RX_D_VLD) err_d = 1'b1;
                // Data arriving on the timeout cycle still completes the read.
                if (RdData_VLD) begin
                    buf_d   = RdData;
                    cnt_d   = '0;
                    state_d = TX_SEND;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_SEND: begin
                if (RX_D_VLD) err_d = 1'b1;
                if (!TX_BUSY) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = buf_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wr_data_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb/tb_reg_cmd_ctrl.sv - self-checking bench for reg_cmd_ctrl
module tb_reg_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RdData;
    logic       RdData_VLD;
    logic       TX_BUSY;
    logic       WrEn, RdEn, TX_D_VLD, ERR;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    reg_cmd_ctrl #(.WIDTH(8), .ADDR(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_VLD(RdData_VLD), .TX_BUSY(TX_BUSY),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    localparam int K_WR = 0, K_RD = 1, K_TX = 2, K_ERR = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];

    function automatic void push(input int k, input int c, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic observe(input int k, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d at cycle %0d addr %0h data %0h, expected none", k, cyc, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.cyc == cyc && e.addr == a && e.data == d) n_pass++;
            else $display("FAIL event: got kind %0d cyc %0d addr %0h data %0h, expected kind %0d cyc %0d addr %0h data %0h",
                          k, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
        end
    endtask

    // Output monitor: every strobe is matched against the scoreboard.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (WrEn && RdEn) begin
                n_total++;
                $display("FAIL wr_rd_overlap: got WrEn=1 RdEn=1 at cycle %0d, expected never both", cyc);
            end
            if (WrEn)     observe(K_WR, Address, WrData);
            if (RdEn)     observe(K_RD, Address, 8'h00);
            if (TX_D_VLD) observe(K_TX, 4'h0, TX_P_DATA);
            if (ERR)      observe(K_ERR, 4'h0, 8'h00);
        end
    end

    task automatic cyc_in(input logic vld, input logic [7:0] d, input logic rdv,
                          input logic [7:0] rdd, input logic busy);
        RX_D_VLD = vld; RX_P_DATA = d; RdData_VLD = rdv; RdData = rdd; TX_BUSY = busy;
        @(negedge CLK);
        RX_D_VLD = 1'b0; RdData_VLD = 1'b0; TX_BUSY = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    typedef struct {
        int         kind;
        logic [7:0] b0, b1, b2;
        int         gap;
        logic [7:0] rdd;
        int         rd_dly;
        int         busy;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        vecs[0] = '{K_WR,  8'hAA, 8'h05, 8'h3C, 0, 8'h00, 0, 0, 4'h5, 8'h3C};
        vecs[1] = '{K_WR,  8'hAA, 8'hF9, 8'h81, 2, 8'h00, 0, 0, 4'h9, 8'h81};
        vecs[2] = '{K_ERR, 8'h55, 8'h00, 8'h00, 0, 8'h00, 0, 0, 4'h0, 8'h00};
        vecs[3] = '{K_WR,  8'hAA, 8'h01, 8'hFF, 0, 8'h00, 0, 0, 4'h1, 8'hFF};
        vecs[4] = '{K_RD,  8'hBB, 8'h02, 8'h00, 0, 8'h21, 1, 0, 4'h2, 8'h21};
        vecs[5] = '{K_RD,  8'hBB, 8'h1E, 8'h00, 1, 8'hC4, 0, 5, 4'hE, 8'hC4};
        vecs[6] = '{K_RD,  8'hBB, 8'h0A, 8'h00, 0, 8'h5A, 7, 0, 4'hA, 8'h5A};
        vecs[7] = '{K_ERR, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 4'h0, 8'h00};
        vecs[8] = '{K_WR,  8'hAA, 8'h0F, 8'h00, 1, 8'h00, 0, 0, 4'hF, 8'h00};

        RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
        RdData = 8'h00; RdData_VLD = 1'b0; TX_BUSY = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_outputs", {22'd0, WrEn, RdEn, Address, TX_D_VLD, ERR}, 32'd0);
        check("reset_data", {8'd0, WrData, TX_P_DATA, 8'd0}, 32'd0);
        RST = 1'b1;
        idle(2);

        // Table-driven commands, issued back to back.
        for (int i = 0; i < 9; i++) begin
            t = cyc;
            if (vecs[i].kind == K_ERR) begin
                push(K_ERR, t + 1, 4'h0, 8'h00);
                cyc_in(1'b1, vecs[i].b0, 1'b0, 8'h00, 1'b0);
            end else begin
                cyc_in(1'b1, vecs[i].b0, 1'b0, 8'h00, 1'b0);
                idle(vecs[i].gap);
                if (vecs[i].kind == K_WR) begin
                    cyc_in(1'b1, vecs[i].b1, 1'b0, 8'h00, 1'b0);
                    idle(vecs[i].gap);
                    t = cyc;
                    push(K_WR, t + 1, vecs[i].exp_addr, vecs[i].exp_data);
                    cyc_in(1'b1, vecs[i].b2, 1'b0, 8'h00, 1'b0);
                end else begin
                    t = cyc;
                    push(K_RD, t + 1, vecs[i].exp_addr, 8'h00);
                    cyc_in(1'b1, vecs[i].b1, 1'b0, 8'h00, 1'b0);
                    idle(vecs[i].rd_dly);
                    t = cyc;
                    push(K_TX, t + vecs[i].busy + 2, 4'h0, vecs[i].exp_data);
                    cyc_in(1'b0, 8'h00, 1'b1, vecs[i].rdd, 1'b0);
                    for (int b = 0; b < vecs[i].busy; b++) cyc_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
                    idle(1);
                end
            end
        end
        idle(3);

        // Stray bytes during RD_WAIT and TX_SEND are flagged and dropped.
        cyc_in(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0);
        t = cyc;
        push(K_RD, t + 1, 4'h6, 8'h00);
        push(K_ERR, t + 3, 4'h0, 8'h00);
        push(K_ERR, t + 5, 4'h0, 8'h00);
        push(K_TX, t + 6, 4'h0, 8'h66);
        cyc_in(1'b1, 8'h06, 1'b0, 8'h00, 1'b0);
        idle(1);
        cyc_in(1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
        cyc_in(1'b0, 8'h00, 1'b1, 8'h66, 1'b0);
        cyc_in(1'b1, 8'h34, 1'b0, 8'h00, 1'b1);
        idle(3);

        // Read timeout, then an immediate write accepted on IDLE re-entry.
        cyc_in(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0);
        t = cyc;
        push(K_RD, t + 1, 4'h3, 8'h00);
        push(K_ERR, t + 9, 4'h0, 8'h00);
        cyc_in(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
        idle(8);
        cyc_in(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        cyc_in(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
        t = cyc;
        push(K_WR, t + 1, 4'h4, 8'h77);
        cyc_in(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
        idle(4);
        check("hold_tx_data", {24'd0, TX_P_DATA}, 32'h66);
        check("hold_address", {28'd0, Address}, 32'h4);
        check("hold_wrdata", {24'd0, WrData}, 32'h77);
        check("scoreboard_drained_pre_reset", exp_q.size(), 0);

        // Reset in the middle of a write abandons it.
        cyc_in(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        cyc_in(1'b1, 8'h07, 1'b0, 8'h00, 1'b0);
        RST = 1'b0;
        #1;
        check("async_reset_outputs", {WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, ERR}, 32'd0);
        @(negedge CLK);
        idle(2);
        check("held_reset_outputs", {WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, ERR}, 32'd0);
        RST = 1'b1;
        t = cyc;
        push(K_ERR, t + 1, 4'h0, 8'h00);
        cyc_in(1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
        idle(12);
        check("post_reset_regs", {Address, WrData, TX_P_DATA}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
